// File: rtl/sad_pkg.sv
// ---------------------------------------------------------------------------
// sad_pkg
// Shared definitions for the SAD engines (sad_cal, sad_stream_cal).
//   - default geometry / width parameters
//   - clog2 and the derived row-sum / block-SAD width helpers
//   - tree_hi: how adder-tree levels are split across register stages
//   - row_tag_t: per-row sideband carried alongside the adder tree
// ---------------------------------------------------------------------------
package sad_pkg;

  localparam int DWIDTH_DEF     = 8;
  localparam int BW_DEF         = 16;
  localparam int BH_DEF         = 16;
  localparam int ADD_STAGES_DEF = 2;
  localparam int CIW_DEF        = 8;

  // Sideband travelling with every row through the tree.
  typedef struct packed {
    logic row0;   // first row of a block: restarts the accumulator
    logic last;   // last row of a block: accumulator holds a full SAD next
    logic first;  // block starts a new candidate search
  } row_tag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Exact width of one row of BW absolute differences.
  function automatic int row_w(input int dw, input int bw);
    return dw + clog2(bw);
  endfunction

  // Exact width of a BWxBH block sum.
  function automatic int sad_w(input int dw, input int bw, input int bh);
    return dw + clog2(bw * bh);
  endfunction

  // Highest tree level completed at the output of register stage s.
  // Levels are spread as evenly as possible over the first min(stages,lvls)
  // stages; any further stages are plain delay stages.
  function automatic int tree_hi(input int s, input int lvls, input int stages);
    int a;
    a = (stages < lvls) ? stages : lvls;
    if (s >= a) return lvls;
    return (s * lvls + a - 1) / a;
  endfunction

endpackage

// File: rtl/sad_row_tree.sv
// ---------------------------------------------------------------------------
// sad_row_tree
// Absolute difference of one BW-pixel row followed by a pipelined adder tree.
// One register stage for |din-refi|, then ADD_STAGES register stages holding
// the partially reduced tree. Every stage advances only when i_en is high;
// i_clr drops all in-flight valids.
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   i_en          pipeline advance enable
//   i_clr         synchronous flush of valids (wins over i_en)
//   i_vld         row accepted this cycle
//   i_tag         row_tag_t bits for the accepted row
//   i_din, i_refi current / reference row, pixel x at [x*DWIDTH +: DWIDTH]
//   o_vld, o_tag  row sum valid and its tag
//   o_sum         exact row sum of absolute differences
// ---------------------------------------------------------------------------
module sad_row_tree
  import sad_pkg::*;
#(
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int BW         = BW_DEF,
  parameter int ADD_STAGES = ADD_STAGES_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_en,
  input  logic                         i_clr,
  input  logic                         i_vld,
  input  logic [2:0]                   i_tag,
  input  logic [BW*DWIDTH-1:0]         i_din,
  input  logic [BW*DWIDTH-1:0]         i_refi,
  output logic                         o_vld,
  output logic [2:0]                   o_tag,
  output logic [row_w(DWIDTH,BW)-1:0]  o_sum
);

  localparam int ROW_W = row_w(DWIDTH, BW);
  localparam int LVLS  = clog2(BW);
  localparam int NP    = 1 << LVLS;      // leaves padded to a power of two
  localparam int VW    = NP * ROW_W;

  // r_node[0] holds the absolute differences, r_node[s] the tree after
  // register stage s. Every node is ROW_W wide so no level can overflow.
  logic [VW-1:0] r_node [0:ADD_STAGES];
  logic          r_vld  [0:ADD_STAGES];
  row_tag_t      r_tag  [0:ADD_STAGES];
  logic [VW-1:0] w_diff;
  row_tag_t      w_tag;

  assign w_tag = row_tag_t'(i_tag);

  // Reduce levels lo+1..hi in place; nodes beyond a level's width are zeroed
  // so the final stage carries only the root.
  function automatic logic [VW-1:0] reduce(input logic [VW-1:0] v,
                                           input int lo, input int hi);
    logic [VW-1:0] t;
    t = v;
    for (int l = lo + 1; l <= hi; l++) begin
      for (int n = 0; n < NP; n++) begin
        if (n < (NP >> l))
          t[n*ROW_W +: ROW_W] = t[2*n*ROW_W +: ROW_W] + t[(2*n+1)*ROW_W +: ROW_W];
        else
          t[n*ROW_W +: ROW_W] = '0;
      end
    end
    return t;
  endfunction

  genvar gi;

  generate
    for (gi = 0; gi < NP; gi++) begin : g_diff
      if (gi < BW) begin : g_px
        logic [DWIDTH-1:0] w_a;
        logic [DWIDTH-1:0] w_b;
        assign w_a = i_din[gi*DWIDTH +: DWIDTH];
        assign w_b = i_refi[gi*DWIDTH +: DWIDTH];
        assign w_diff[gi*ROW_W +: ROW_W] =
          ROW_W'((w_a > w_b) ? (w_a - w_b) : (w_b - w_a));
      end else begin : g_pad
        assign w_diff[gi*ROW_W +: ROW_W] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_node[0] <= '0;
      r_vld[0]  <= 1'b0;
      r_tag[0]  <= '0;
    end else if (i_clr) begin
      r_vld[0]  <= 1'b0;
    end else if (i_en) begin
      r_node[0] <= w_diff;
      r_vld[0]  <= i_vld;
      r_tag[0]  <= w_tag;
    end
  end

  generate
    for (gi = 1; gi <= ADD_STAGES; gi++) begin : g_stage
      localparam int LO = tree_hi(gi - 1, LVLS, ADD_STAGES);
      localparam int HI = tree_hi(gi, LVLS, ADD_STAGES);
      logic [VW-1:0] w_red;

      assign w_red = reduce(r_node[gi-1], LO, HI);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_node[gi] <= '0;
          r_vld[gi]  <= 1'b0;
          r_tag[gi]  <= '0;
        end else if (i_clr) begin
          r_vld[gi]  <= 1'b0;
        end else if (i_en) begin
          r_node[gi] <= w_red;
          r_vld[gi]  <= r_vld[gi-1];
          r_tag[gi]  <= r_tag[gi-1];
        end
      end
    end
  endgenerate

  assign o_vld = r_vld[ADD_STAGES];
  assign o_tag = r_tag[ADD_STAGES];
  assign o_sum = r_node[ADD_STAGES][ROW_W-1:0];

endmodule

// File: rtl/sad_stream_cal.sv
// ---------------------------------------------------------------------------
// sad_stream_cal
// Row-serial block SAD engine with best-candidate tracking for motion search.
// One BW-pixel row per accepted beat; BH rows form one block SAD. Results
// leave through a single output register with valid/ready handshake; the
// whole pipeline stalls while a result waits, so nothing is dropped.
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   i_clr                  synchronous flush of the partial block / pipeline
//   i_in_vld, o_in_rdy     row beat handshake
//   i_in_first             with row 0: start a new candidate search
//   i_din, i_refi          current / reference row, pixel x at [x*DWIDTH +: DWIDTH]
//   o_out_vld, i_out_rdy   result handshake
//   o_sad, o_sad_idx       block SAD and its candidate index
//   o_best_sad, o_best_idx minimum SAD of the search so far and its index
// Latency: last row accepted on edge t -> o_out_vld after edge t+ADD_STAGES+2.
// ---------------------------------------------------------------------------
module sad_stream_cal
  import sad_pkg::*;
#(
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int BW         = BW_DEF,
  parameter int BH         = BH_DEF,
  parameter int ADD_STAGES = ADD_STAGES_DEF,
  parameter int CIW        = CIW_DEF
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            i_clr,
  input  logic                            i_in_vld,
  output logic                            o_in_rdy,
  input  logic                            i_in_first,
  input  logic [BW*DWIDTH-1:0]            i_din,
  input  logic [BW*DWIDTH-1:0]            i_refi,
  output logic                            o_out_vld,
  input  logic                            i_out_rdy,
  output logic [sad_w(DWIDTH,BW,BH)-1:0]  o_sad,
  output logic [CIW-1:0]                  o_sad_idx,
  output logic [sad_w(DWIDTH,BW,BH)-1:0]  o_best_sad,
  output logic [CIW-1:0]                  o_best_idx
);

  localparam int ROW_W = row_w(DWIDTH, BW);
  localparam int SAD_W = sad_w(DWIDTH, BW, BH);
  localparam int RCW   = (BH > 1) ? clog2(BH) : 1;
  localparam logic [RCW-1:0] LAST_ROW = RCW'(BH - 1);
  localparam logic [CIW-1:0] IDX_MAX  = '1;

  logic             r_run;          // low only until the first edge after reset
  logic             w_en;
  logic             w_accept;
  logic [RCW-1:0]   r_row;
  logic             r_force_first;  // next block opens a search regardless of i_in_first
  row_tag_t         w_in_tag;
  logic [2:0]       w_in_tag_bits;

  logic             w_row_vld;
  logic [2:0]       w_row_tag_bits;
  row_tag_t         w_row_tag;
  logic [ROW_W-1:0] w_row_sum;

  logic [SAD_W-1:0] r_acc;
  logic             r_acc_done;     // r_acc holds a complete block
  logic             r_acc_first;    // first flag captured at row 0 of that block
  logic [CIW-1:0]   w_new_idx;

  // A pending result that is not being taken freezes everything upstream.
  assign w_en     = r_run & ~(o_out_vld & ~i_out_rdy) & ~i_clr;
  assign o_in_rdy = w_en;
  assign w_accept = i_in_vld & w_en;

  always_comb begin
    w_in_tag       = '0;
    w_in_tag.row0  = (r_row == '0);
    w_in_tag.last  = (r_row == LAST_ROW);
    w_in_tag.first = (r_row == '0) & (i_in_first | r_force_first);
  end

  assign w_in_tag_bits = w_in_tag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_run         <= 1'b0;
      r_row         <= '0;
      r_force_first <= 1'b1;
    end else begin
      r_run <= 1'b1;
      if (i_clr) begin
        r_row         <= '0;
        r_force_first <= 1'b1;
      end else if (w_accept) begin
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + RCW'(1);
        if (w_in_tag.row0) r_force_first <= 1'b0;
      end
    end
  end

  sad_row_tree #(
    .DWIDTH     (DWIDTH),
    .BW         (BW),
    .ADD_STAGES (ADD_STAGES)
  ) u_row_tree (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (w_en),
    .i_clr  (i_clr),
    .i_vld  (w_accept),
    .i_tag  (w_in_tag_bits),
    .i_din  (i_din),
    .i_refi (i_refi),
    .o_vld  (w_row_vld),
    .o_tag  (w_row_tag_bits),
    .o_sum  (w_row_sum)
  );

  assign w_row_tag = row_tag_t'(w_row_tag_bits);

  // Block accumulator: row 0 restarts the sum instead of adding to it, so
  // back-to-back blocks need no idle beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc       <= '0;
      r_acc_done  <= 1'b0;
      r_acc_first <= 1'b0;
    end else if (i_clr) begin
      r_acc       <= '0;
      r_acc_done  <= 1'b0;
    end else if (w_en) begin
      r_acc_done <= w_row_vld & w_row_tag.last;
      if (w_row_vld) begin
        r_acc <= (w_row_tag.row0 ? '0 : r_acc) + SAD_W'(w_row_sum);
        if (w_row_tag.row0) r_acc_first <= w_row_tag.first;
      end
    end
  end

  // Candidate index of the block about to be emitted; saturates at the top.
  always_comb begin
    w_new_idx = '0;
    if (!r_acc_first)
      w_new_idx = (o_sad_idx == IDX_MAX) ? IDX_MAX : o_sad_idx + CIW'(1);
  end

  // Output register and min tracker. With w_en high the current result is
  // either absent or being taken this edge, so out_vld simply follows done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_out_vld  <= 1'b0;
      o_sad      <= '0;
      o_sad_idx  <= '0;
      o_best_sad <= '0;
      o_best_idx <= '0;
    end else if (i_clr) begin
      o_out_vld  <= 1'b0;
      o_sad_idx  <= '0;
    end else if (w_en) begin
      o_out_vld <= r_acc_done;
      if (r_acc_done) begin
        o_sad     <= r_acc;
        o_sad_idx <= w_new_idx;
        // strict compare: ties keep the earlier candidate
        if (r_acc_first || (r_acc < o_best_sad)) begin
          o_best_sad <= r_acc;
          o_best_idx <= w_new_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_stream_cal.sv
// ---------------------------------------------------------------------------
// tb_sad_stream_cal
// Directed bench for sad_stream_cal (16x16 blocks, 8-bit pixels, 2 tree
// stages). Stimulus pushes the hand-computed expected result of each block
// into a queue; a monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_sad_stream_cal;

  localparam int DW = 8;
  localparam int BW = 16;
  localparam int BH = 16;
  localparam int AS = 2;
  localparam int CIW = 8;

  logic              clk;
  logic              rstn;
  logic              i_clr;
  logic              i_in_vld;
  logic              o_in_rdy;
  logic              i_in_first;
  logic [BW*DW-1:0]  i_din;
  logic [BW*DW-1:0]  i_refi;
  logic              o_out_vld;
  logic              i_out_rdy;
  logic [15:0]       o_sad;
  logic [CIW-1:0]    o_sad_idx;
  logic [15:0]       o_best_sad;
  logic [CIW-1:0]    o_best_idx;

  logic rdy_rand;
  logic rdy_hold;
  logic rand_bit;

  typedef struct {
    int sad;
    int idx;
    int best;
    int bidx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec;
  int   n_err;

  sad_stream_cal #(
    .DWIDTH     (DW),
    .BW         (BW),
    .BH         (BH),
    .ADD_STAGES (AS),
    .CIW        (CIW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_clr      (i_clr),
    .i_in_vld   (i_in_vld),
    .o_in_rdy   (o_in_rdy),
    .i_in_first (i_in_first),
    .i_din      (i_din),
    .i_refi     (i_refi),
    .o_out_vld  (o_out_vld),
    .i_out_rdy  (i_out_rdy),
    .o_sad      (o_sad),
    .o_sad_idx  (o_sad_idx),
    .o_best_sad (o_best_sad),
    .o_best_idx (o_best_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i_out_rdy = rdy_rand ? rand_bit : rdy_hold;

  initial begin
    rand_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rand_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic timeout(input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out, required DUT progress", what);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "bench stopped on timeout");
  endtask

  task automatic push(input int s, input int idx, input int b, input int bi);
    exp_t e;
    e.sad = s; e.idx = idx; e.best = b; e.bidx = bi;
    exp_q.push_back(e);
  endtask

  // Monitor: compare on every result handshake that is not overridden by clr.
  always @(negedge clk) begin
    if (rstn && o_out_vld && i_out_rdy && !i_clr) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got sad=%0d idx=%0d, required no output", o_sad, o_sad_idx);
      end else begin
        mon_e = exp_q.pop_front();
        $display("[%0t] result sad=%0d idx=%0d best=%0d best_idx=%0d", $time, o_sad, o_sad_idx, o_best_sad, o_best_idx);
        check("sad", 32'(o_sad), mon_e.sad);
        check("sad_idx", 32'(o_sad_idx), mon_e.idx);
        check("best_sad", 32'(o_best_sad), mon_e.best);
        check("best_idx", 32'(o_best_idx), mon_e.bidx);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send_row(input logic [BW*DW-1:0] d, input logic [BW*DW-1:0] r,
                          input logic first, input int gap);
    int k;
    repeat (gap) begin @(posedge clk); #1; end
    i_din = d; i_refi = r; i_in_first = first; i_in_vld = 1'b1;
    k = 0;
    @(negedge clk);
    while (!o_in_rdy) begin
      k++;
      if (k > 2000) timeout("in_rdy_wait");
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    i_in_vld = 1'b0;
    i_in_first = 1'b0;
  endtask

  task automatic send_const(input logic [7:0] dv, input logic [7:0] rv, input logic first);
    for (int r = 0; r < BH; r++)
      send_row({BW{dv}}, {BW{rv}}, first && (r == 0), 0);
  endtask

  // Block whose SAD equals s: differences packed greedily into cells,
  // alternating which side is larger; unused cells carry equal pixels.
  // stray puts in_first on a middle row, where it must be ignored.
  task automatic send_fill(input int s, input logic first, input int nrows,
                           input int max_gap, input logic stray);
    int rem;
    int d;
    int gap;
    logic [BW*DW-1:0] dv;
    logic [BW*DW-1:0] rv;
    rem = s;
    for (int r = 0; r < nrows; r++) begin
      for (int x = 0; x < BW; x++) begin
        d = (rem > 255) ? 255 : rem;
        rem -= d;
        if (d == 0) begin
          dv[x*DW +: DW] = 8'h5A; rv[x*DW +: DW] = 8'h5A;
        end else if (((r * BW + x) % 2) == 1) begin
          dv[x*DW +: DW] = 8'(d); rv[x*DW +: DW] = 8'h00;
        end else begin
          dv[x*DW +: DW] = 8'h00; rv[x*DW +: DW] = 8'(d);
        end
      end
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      send_row(dv, rv, (first && (r == 0)) || (stray && (r == BH / 2)), gap);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      k++;
      if (k > 5000) timeout("drain");
    end
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    n_vec = 0; n_err = 0;
    rstn = 1'b0; i_clr = 1'b0; i_in_vld = 1'b0; i_in_first = 1'b0;
    i_din = '0; i_refi = '0; rdy_rand = 1'b0; rdy_hold = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_rdy", 32'(o_in_rdy), 0);
    check("rst_out_vld", 32'(o_out_vld), 0);
    check("rst_sad", 32'(o_sad), 0);
    check("rst_sad_idx", 32'(o_sad_idx), 0);
    check("rst_best_sad", 32'(o_best_sad), 0);
    check("rst_best_idx", 32'(o_best_idx), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("post_rst_in_rdy", 32'(o_in_rdy), 1);

    // all-zero block plus latency from last accept to out_vld
    push(0, 0, 0, 0);
    send_const(8'h00, 8'h00, 1'b1);
    k = 0;
    while (!o_out_vld && k < 20) begin @(posedge clk); #1; k++; end
    check("latency", k, AS + 2);
    push(65280, 1, 0, 0);
    send_const(8'h00, 8'hFF, 1'b0);
    push(0, 2, 0, 0);
    send_const(8'hFF, 8'hFF, 1'b0);

    // four-candidate search with tie and a stray in_first mid-block
    push(500, 0, 500, 0);
    send_fill(500, 1'b1, BH, 0, 1'b0);
    push(300, 1, 300, 1);
    send_fill(300, 1'b0, BH, 0, 1'b0);
    push(300, 2, 300, 1);
    send_fill(300, 1'b0, BH, 0, 1'b1);
    push(700, 3, 300, 1);
    send_fill(700, 1'b0, BH, 0, 1'b0);
    wait_drain();

    // backpressure: results held, input stalls, nothing lost
    rdy_hold = 1'b0;
    push(100, 0, 100, 0);
    push(50, 1, 50, 1);
    push(2000, 2, 50, 1);
    fork
      begin
        send_fill(100, 1'b1, BH, 0, 1'b0);
        send_fill(50, 1'b0, BH, 0, 1'b0);
        send_fill(2000, 1'b0, BH, 0, 1'b0);
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!o_out_vld) begin
          w++;
          if (w > 2000) timeout("bp_first_result");
          @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("bp_in_rdy", 32'(o_in_rdy), 0);
        check("bp_out_vld", 32'(o_out_vld), 1);
        check("bp_sad_held", 32'(o_sad), 100);
        @(posedge clk); #1;
        rdy_hold = 1'b1;
      end
    join
    wait_drain();

    // candidate index saturation at 255; best index follows saturated value
    for (int i = 0; i < 257; i++) begin
      if (i == 0) begin
        push(200, 0, 200, 0);
        send_fill(200, 1'b1, BH, 0, 1'b0);
      end else if (i < 256) begin
        push(100, i, 100, 1);
        send_fill(100, 1'b0, BH, 0, 1'b0);
      end else begin
        push(50, 255, 50, 255);
        send_fill(50, 1'b0, BH, 0, 1'b0);
      end
    end
    wait_drain();

    // clr after row 7: partial block discarded, next block restarts search
    send_fill(400, 1'b0, 8, 0, 1'b0);
    i_clr = 1'b1;
    @(negedge clk);
    check("clr_in_rdy", 32'(o_in_rdy), 0);
    @(posedge clk); #1;
    i_clr = 1'b0;
    push(123, 0, 123, 0);
    send_fill(123, 1'b0, BH, 0, 1'b0);
    wait_drain();

    // async reset right after a block's last row: its result must never appear
    send_fill(777, 1'b1, BH, 0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("arst_out_vld", 32'(o_out_vld), 0);
    check("arst_in_rdy", 32'(o_in_rdy), 0);
    check("arst_sad", 32'(o_sad), 0);
    check("arst_best_sad", 32'(o_best_sad), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    push(42, 0, 42, 0);
    send_fill(42, 1'b0, BH, 0, 1'b0);
    wait_drain();

    // random out_rdy stalls and in_vld gaps
    rdy_rand = 1'b1;
    push(1000, 0, 1000, 0);
    send_fill(1000, 1'b1, BH, 2, 1'b0);
    push(1000, 1, 1000, 0);
    send_fill(1000, 1'b0, BH, 2, 1'b1);
    push(999, 2, 999, 2);
    send_fill(999, 1'b0, BH, 2, 1'b0);
    push(65280, 3, 999, 2);
    send_fill(65280, 1'b0, BH, 2, 1'b0);
    wait_drain();
    rdy_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
